// File: rtl/data_ram_ctrl.sv
// Byte-addressed data RAM with a two-state buffered write port and a
// single-cycle-latency read port; the low cells double as configuration registers.
module data_ram_ctrl #(
    parameter int ADDR_DEPTH          = 2048,
    parameter int ADDR_WIDTH          = $clog2(ADDR_DEPTH),
    parameter int RESERVED_REG_AMOUNT = 1,
    parameter logic [RESERVED_REG_AMOUNT*8-1:0] RESERVED_REG_DEFAULT = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_ins,
    input  logic [ADDR_WIDTH-1:0]            addr_wr,
    input  logic [1:0]                       data_type_wr,
    input  logic [63:0]                      data_bus_wr,
    output logic                             wr_idle,
    output logic                             wr_done,
    output logic                             wr_err,
    input  logic                             rd_ins,
    input  logic [ADDR_WIDTH-1:0]            addr_rd,
    input  logic [1:0]                       data_type_rd,
    input  logic                             rd_signed,
    output logic [63:0]                      data_bus_rd,
    output logic                             rd_valid,
    output logic                             rd_err,
    output logic [RESERVED_REG_AMOUNT*8-1:0] reserved_registers
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_X   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_DEPTH*8-1:0] RESET_IMAGE = (ADDR_DEPTH*8)'(RESERVED_REG_DEFAULT);

    logic [7:0]            mem [ADDR_DEPTH];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] wr_addr_p0;
    logic [1:0]            wr_type_p0;
    logic [63:0]           wr_data_p0;
    logic                  wr_legal_p0;
    logic                  commit_en;
    logic                  rd_legal;
    logic [63:0]           rd_raw;

    function automatic logic [3:0] size_bytes(input logic [1:0] dtype);
        return 4'd1 << dtype;
    endfunction

    // Extended by one bit so addr+N can never wrap back into the legal range.
    function automatic logic access_legal(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [1:0]            dtype);
        logic [ADDR_WIDTH:0] n;
        logic [ADDR_WIDTH:0] last;
        n    = (ADDR_WIDTH+1)'(size_bytes(dtype));
        last = {1'b0, addr} + n;
        return ((({1'b0, addr}) & (n - ONE_X)) == '0) && (last <= DEPTH_X);
    endfunction

    function automatic logic [63:0] extend_read(input logic [63:0] raw,
                                                input logic [1:0]  dtype,
                                                input logic        sgn);
        logic [63:0] res;
        case (dtype)
            2'd0:    res = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    res = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    res = {{32{sgn & raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Stage p0: write request capture
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr_ins) begin
            wr_addr_p0  <= addr_wr;
            wr_type_p0  <= data_type_wr;
            wr_data_p0  <= data_bus_wr;
            wr_legal_p0 <= access_legal(addr_wr, data_type_wr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_ins) state <= ST_COMMIT;
                end
                default: begin
                    state   <= ST_IDLE;
                    wr_done <= wr_legal_p0;
                    wr_err  <= ~wr_legal_p0;
                end
            endcase
        end
    end

    assign wr_idle   = (state == ST_IDLE);
    assign commit_en = (state == ST_COMMIT) && wr_legal_p0;

    // Stage p1: storage update; an async reset also drops a pending commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADDR_DEPTH; i++) mem[i] <= RESET_IMAGE[8*i +: 8];
        end else if (commit_en) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(size_bytes(wr_type_p0)))
                    mem[wr_addr_p0 + ADDR_WIDTH'(k)] <= wr_data_p0[8*k +: 8];
            end
        end
    end

    // All eight bytes are gathered; extend_read masks by size, wrapped indices are discarded.
    always_comb begin
        rd_raw = '0;
        for (int k = 0; k < 8; k++) rd_raw[8*k +: 8] = mem[addr_rd + ADDR_WIDTH'(k)];
    end

    assign rd_legal = access_legal(addr_rd, data_type_rd);

    // Stage p1: registered read result, sees storage before any same-edge commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid    <= 1'b0;
            rd_err      <= 1'b0;
            data_bus_rd <= '0;
        end else begin
            rd_valid <= rd_ins;
            rd_err   <= rd_ins & ~rd_legal;
            if (rd_ins) data_bus_rd <= rd_legal ? extend_read(rd_raw, data_type_rd, rd_signed) : 64'd0;
        end
    end

    genvar g;
    for (g = 0; g < RESERVED_REG_AMOUNT; g++) begin : g_resv
        assign reserved_registers[8*g +: 8] = mem[g];
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_ram_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int RA    = 4;
    localparam logic [RA*8-1:0] RDEF = 32'hDEAD_5AC3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_ins = 1'b0;
    logic [AW-1:0] addr_wr = '0;
    logic [1:0]    data_type_wr = '0;
    logic [63:0]   data_bus_wr = '0;
    logic          wr_idle, wr_done, wr_err;
    logic          rd_ins = 1'b0;
    logic [AW-1:0] addr_rd = '0;
    logic [1:0]    data_type_rd = '0;
    logic          rd_signed = 1'b0;
    logic [63:0]   data_bus_rd;
    logic          rd_valid, rd_err;
    logic [RA*8-1:0] reserved_registers;

    data_ram_ctrl #(
        .ADDR_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .RESERVED_REG_AMOUNT(RA), .RESERVED_REG_DEFAULT(RDEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_ins(wr_ins), .addr_wr(addr_wr), .data_type_wr(data_type_wr), .data_bus_wr(data_bus_wr),
        .wr_idle(wr_idle), .wr_done(wr_done), .wr_err(wr_err),
        .rd_ins(rd_ins), .addr_rd(addr_rd), .data_type_rd(data_type_rd), .rd_signed(rd_signed),
        .data_bus_rd(data_bus_rd), .rd_valid(rd_valid), .rd_err(rd_err),
        .reserved_registers(reserved_registers)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [63:0] last_rd = '0;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input int addr, input int t);
        int n = 1 << t;
        return (addr % n == 0) && (addr + n <= DEPTH);
    endfunction

    function automatic logic [63:0] model_read(input int addr, input int t, input bit sgn);
        int n = 1 << t;
        int sh;
        logic [63:0] v = '0;
        logic signed [63:0] s;
        if (!model_legal(addr, t)) return 64'd0;
        for (int k = n - 1; k >= 0; k--) v = (v << 8) | 64'(ref_mem[addr + k]);
        if (sgn && n < 8) begin
            sh = 64 - 8 * n;
            s = $signed(v << sh);
            s = s >>> sh;
            v = s;
        end
        return v;
    endfunction

    function automatic void model_write(input int addr, input int t, input logic [63:0] d);
        int n = 1 << t;
        if (!model_legal(addr, t)) return;
        for (int k = 0; k < n; k++) ref_mem[addr + k] = d[8*k +: 8];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 8'h00;
            if (i < RA) ref_mem[i] = RDEF[8*i +: 8];
        end
    endfunction

    function automatic logic [RA*8-1:0] model_reserved();
        logic [RA*8-1:0] r;
        for (int i = 0; i < RA; i++) r[8*i +: 8] = ref_mem[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int t, input logic [63:0] d, input string tag);
        int w = 0;
        while (!wr_idle && w < 4) begin
            tick();
            w++;
        end
        chk({tag, "_idle"}, 64'(wr_idle), 64'd1);
        wr_ins = 1'b1; addr_wr = AW'(addr); data_type_wr = 2'(t); data_bus_wr = d;
        tick();
        wr_ins = 1'b0;
        chk({tag, "_busy"}, 64'(wr_idle), 64'd0);
        chk({tag, "_early"}, 64'(wr_done), 64'd0);
        tick();
        chk({tag, "_done"}, 64'(wr_done), 64'(model_legal(addr, t)));
        chk({tag, "_err"}, 64'(wr_err), 64'(!model_legal(addr, t)));
        model_write(addr, t, d);
    endtask

    task automatic do_read(input int addr, input int t, input bit sgn, input string tag);
        logic [63:0] exp;
        exp = model_read(addr, t, sgn);
        rd_ins = 1'b1; addr_rd = AW'(addr); data_type_rd = 2'(t); rd_signed = sgn;
        tick();
        rd_ins = 1'b0;
        chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
        chk({tag, "_rerr"}, 64'(rd_err), 64'(!model_legal(addr, t)));
        chk({tag, "_data"}, data_bus_rd, exp);
        last_rd = exp;
    endtask

    initial begin
        logic [63:0] bp_data [4];
        logic [63:0] exp_old;
        int done_cnt;
        int a, t, n;
        bit s;
        int rexp_legal [16];
        logic [63:0] rexp [16];

        model_reset();
        #12;
        chk("rst_idle", 64'(wr_idle), 64'd1);
        chk("rst_done", 64'(wr_done), 64'd0);
        chk("rst_werr", 64'(wr_err), 64'd0);
        chk("rst_vld", 64'(rd_valid), 64'd0);
        chk("rst_rerr", 64'(rd_err), 64'd0);
        chk("rst_data", data_bus_rd, 64'd0);
        chk("rst_resv", 64'(reserved_registers), 64'(RDEF));
        rst_n = 1'b1;
        tick();

        // dword write then read
        do_write(16'h10, 3, 64'h8877665544332211, "dw_wr");
        do_read(16'h10, 3, 1'b0, "dw_rd");
        chk("dw_const", data_bus_rd, 64'h8877665544332211);
        tick();
        chk("hold_vld", 64'(rd_valid), 64'd0);
        chk("hold_err", 64'(rd_err), 64'd0);
        chk("hold_data", data_bus_rd, last_rd);

        // sign extension
        do_write(16'h21, 0, 64'h80, "sx_wr");
        do_read(16'h21, 0, 1'b1, "sx_b_s");
        chk("sx_b_s_const", data_bus_rd, 64'hFFFF_FFFF_FFFF_FF80);
        do_read(16'h21, 0, 1'b0, "sx_b_u");
        chk("sx_b_u_const", data_bus_rd, 64'h80);
        do_read(16'h20, 1, 1'b1, "sx_h_s");
        chk("sx_h_s_const", data_bus_rd, 64'hFFFF_FFFF_FFFF_8000);

        // illegal accesses
        do_write(16'h06, 2, 64'hDEADBEEF, "ill_wr");
        do_read(16'h00, 3, 1'b0, "ill_chk0");
        do_read(16'h08, 3, 1'b0, "ill_chk8");
        chk("ill_chk8_const", data_bus_rd, 64'd0);
        do_read(DEPTH - 4, 3, 1'b0, "ill_rd_top");
        chk("ill_rd_top_const", data_bus_rd, 64'd0);
        do_read(16'h03, 1, 1'b0, "ill_rd_half");
        chk("ill_rd_half_err", 64'(rd_err), 64'd1);

        // reserved cells track writes
        do_write(1, 0, 64'h7E, "resv_wr");
        chk("resv_live", 64'(reserved_registers), 64'(model_reserved()));

        // read/commit collision: no forwarding
        wr_ins = 1'b1; addr_wr = 8'h40; data_type_wr = 2'd0; data_bus_wr = 64'hAA;
        tick();
        wr_ins = 1'b0;
        exp_old = model_read(16'h40, 0, 1'b0);
        rd_ins = 1'b1; addr_rd = 8'h40; data_type_rd = 2'd0; rd_signed = 1'b0;
        tick();
        rd_ins = 1'b0;
        chk("col_old", data_bus_rd, exp_old);
        chk("col_old_const", data_bus_rd, 64'h00);
        chk("col_done", 64'(wr_done), 64'd1);
        model_write(16'h40, 0, 64'hAA);
        do_read(16'h40, 0, 1'b0, "col_new");
        chk("col_new_const", data_bus_rd, 64'hAA);

        // wr_ins held for four cycles: only idle-cycle requests are taken
        done_cnt = 0;
        wr_ins = 1'b1; data_type_wr = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bp_data[i] = {$urandom, $urandom};
            addr_wr = AW'(16'h80 + 8 * i); data_bus_wr = bp_data[i];
            tick();
            if (wr_done) done_cnt++;
            chk("bp_idle", 64'(wr_idle), 64'(i % 2));
        end
        wr_ins = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wr_done) done_cnt++;
        end
        chk("bp_commits", 64'(done_cnt), 64'd2);
        model_write(16'h80, 3, bp_data[0]);
        model_write(16'h90, 3, bp_data[2]);
        for (int i = 0; i < 4; i++) do_read(16'h80 + 8 * i, 3, 1'b0, "bp_rd");

        // reset while a write sits in COMMIT
        wr_ins = 1'b1; addr_wr = 8'h00; data_type_wr = 2'd0; data_bus_wr = 64'h55;
        tick();
        wr_ins = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_idle", 64'(wr_idle), 64'd1);
        chk("mrst_done", 64'(wr_done), 64'd0);
        chk("mrst_vld", 64'(rd_valid), 64'd0);
        chk("mrst_data", data_bus_rd, 64'd0);
        chk("mrst_resv", 64'(reserved_registers), 64'(RDEF));
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("mrst_nodone", 64'(wr_done), 64'd0);
        chk("mrst_noerr", 64'(wr_err), 64'd0);
        do_read(0, 0, 1'b0, "mrst_cell0");
        chk("mrst_cell0_const", data_bus_rd, 64'(RDEF[7:0]));
        do_read(16'h40, 0, 1'b0, "mrst_cleared");

        // randomized mixed traffic
        for (int i = 0; i < 150; i++) begin
            t = $urandom_range(0, 3);
            n = 1 << t;
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) do_write(a, t, {$urandom, $urandom}, "rnd_wr");
            else do_read(a, t, s, "rnd_rd");
        end
        chk("rnd_resv", 64'(reserved_registers), 64'(model_reserved()));

        // back-to-back reads every cycle
        rd_ins = 1'b1;
        for (int i = 0; i < 16; i++) begin
            t = $urandom_range(0, 3);
            a = $urandom_range(0, DEPTH - 1);
            if (i % 3 != 0) a = a & ~((1 << t) - 1);
            s = 1'($urandom_range(0, 1));
            addr_rd = AW'(a); data_type_rd = 2'(t); rd_signed = s;
            rexp[i] = model_read(a, t, s);
            rexp_legal[i] = int'(model_legal(a, t));
            tick();
            chk("b2b_vld", 64'(rd_valid), 64'd1);
            chk("b2b_err", 64'(rd_err), 64'(rexp_legal[i] == 0));
            chk("b2b_data", data_bus_rd, rexp[i]);
        end
        rd_ins = 1'b0;
        tick();
        chk("b2b_end_vld", 64'(rd_valid), 64'd0);
        chk("b2b_end_hold", data_bus_rd, rexp[15]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
